// File: rtl/usb_slave_fifo_rx.sv
`timescale 1ns/1ps
// usb_slave_fifo_rx
// Read engine for the FX2 synchronous slave-FIFO interface (EP2 OUT).
// Drains bytes over FD into a small circular buffer and presents them as a
// valid/ready byte stream.
//
// Ports:
//   USB_CLKO          FX2 interface clock, all logic on rising edge
//   USB_RESET2        asynchronous active-low reset
//   USB_FLAG_EMPTY_N  EP2 flag, 1 = at least one byte available
//   USB_FD            FX2 FIFO data bus (sampled only)
//   USB_SLOE          FIFO output enable, active-low, registered
//   USB_SLRD          FIFO read strobe, active-low, registered
//   USB_FIFOADR       endpoint select, tied to EP2 (2'b00)
//   M_DATA/M_VALID    head byte of buffer / buffer non-empty
//   M_READY           downstream accepts M_DATA this cycle
//   LEVEL             bytes currently buffered, 0..DEPTH
module usb_slave_fifo_rx #(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  USB_CLKO,
    input  logic                  USB_RESET2,
    input  logic                  USB_FLAG_EMPTY_N,
    input  logic [7:0]            USB_FD,
    output logic                  USB_SLOE,
    output logic                  USB_SLRD,
    output logic [1:0]            USB_FIFOADR,
    output logic [7:0]            M_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DEPTH_LOG2:0]   LEVEL
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OE,
        S_RD,
        S_GAP
    } state_t;

    state_t                  state_q, state_d;
    logic                    sloe_q, sloe_d;
    logic                    slrd_q, slrd_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [7:0]              mem [DEPTH];

    logic push;
    logic pop;
    logic room;

    // Room is judged on the count before this edge's push/pop, so a read
    // committed here always has a free slot when its byte lands.
    assign room = (count_q != FULL_COUNT);
    assign push = (state_q == S_RD);
    assign pop  = (count_q != '0) && M_READY;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (USB_FLAG_EMPTY_N && room) state_d = S_OE;
            S_OE:    state_d = S_RD;
            S_RD:    state_d = S_GAP;
            S_GAP:   state_d = (USB_FLAG_EMPTY_N && room) ? S_RD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Strobes are decoded from the next state so the pins come
        // straight off flops aligned with the state register.
        sloe_d = (state_d == S_IDLE);
        slrd_d = (state_d != S_RD);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge USB_CLKO or negedge USB_RESET2) begin
        if (!USB_RESET2) begin
            state_q  <= S_IDLE;
            sloe_q   <= 1'b1;
            slrd_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sloe_q   <= sloe_d;
            slrd_q   <= slrd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; push is gated by the reset-cleared state.
    always_ff @(posedge USB_CLKO) begin
        if (push) mem[wr_ptr_q] <= USB_FD;
    end

    assign USB_SLOE    = sloe_q;
    assign USB_SLRD    = slrd_q;
    assign USB_FIFOADR = 2'b00;
    assign M_DATA      = mem[rd_ptr_q];
    assign M_VALID     = (count_q != '0);
    assign LEVEL       = count_q;

endmodule

// File: tb/tb_usb_slave_fifo_rx.sv
`timescale 1ns/1ps
// Self-checking bench for usb_slave_fifo_rx: an FX2 EP2 model feeds FD and
// the flag, a scoreboard queue holds bytes strobed out of the model, and a
// negedge monitor compares delivered bytes and LEVEL against the model.
module tb_usb_slave_fifo_rx;

    localparam int unsigned DEPTH_LOG2 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag;
    logic [7:0] fd;
    logic       sloe, slrd;
    logic [1:0] fifoadr;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] level;

    always #5 clk = ~clk;

    usb_slave_fifo_rx #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .USB_CLKO         (clk),
        .USB_RESET2       (rst_n),
        .USB_FLAG_EMPTY_N (flag),
        .USB_FD           (fd),
        .USB_SLOE         (sloe),
        .USB_SLRD         (slrd),
        .USB_FIFOADR      (fifoadr),
        .M_DATA           (m_data),
        .M_VALID          (m_valid),
        .M_READY          (m_ready),
        .LEVEL            (level)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fx2_q[$];
    logic [7:0] exp_q[$];
    bit         fx2_en = 1'b0;
    int         model_level = 0;
    int         strobes = 0;
    int         popped = 0;
    int         cyc = 0;
    int         first_strobe_cyc = -1;
    int         last_strobe_cyc = -1;

    // FX2 model + scoreboard monitor. Checks at negedge, model pins update
    // 2 ns after posedge (stimulus tasks act at 1 ns after posedge).
    always begin : fx2_model
        logic       pend;
        logic [7:0] e;
        @(negedge clk);
        cyc++;
        checks++;
        if (level !== 4'(model_level)) begin
            errors++;
            $display("FAIL level: got %0d expected %0d (cycle %0d)", level, model_level, cyc);
        end
        checks++;
        if (m_valid !== (model_level != 0)) begin
            errors++;
            $display("FAIL m_valid: got %b expected %b (cycle %0d)", m_valid, model_level != 0, cyc);
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got byte %02h expected none (cycle %0d)", m_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %02h expected %02h (cycle %0d)", m_data, e, cyc);
                end
            end
            popped++;
            model_level--;
        end
        pend = 1'b0;
        if (slrd === 1'b0) begin
            strobes++;
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            last_strobe_cyc = cyc;
            if (fx2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_empty: got strobe expected none (cycle %0d)", cyc);
            end else begin
                exp_q.push_back(fx2_q[0]);
                model_level++;
                pend = 1'b1;
            end
        end
        @(posedge clk);
        #2;
        if (pend && fx2_q.size() > 0) void'(fx2_q.pop_front());
        fd   = (fx2_q.size() > 0) ? fx2_q[0] : 8'hEE;
        flag = fx2_en && (fx2_q.size() > 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fx2_q = '{8'h11, 8'h22};
        fx2_en = 1'b1;
        repeat (4) begin
            tick();
            checks++;
            if (sloe !== 1'b1 || slrd !== 1'b1) begin
                errors++;
                $display("FAIL reset_strobes: got sloe=%b slrd=%b expected 1 1", sloe, slrd);
            end
            checks++;
            if (m_valid !== 1'b0 || level !== 4'd0 || fifoadr !== 2'b00) begin
                errors++;
                $display("FAIL reset_state: got valid=%b level=%0d adr=%b expected 0 0 00",
                         m_valid, level, fifoadr);
            end
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL reset_no_reads: got %0d strobes expected 0", strobes);
        end
        fx2_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_byte();
        int s0 = strobes;
        int p0 = popped;
        m_ready = 1'b1;
        fx2_q.push_back(8'hA5);
        tick();  // E0: flag seen -> OE
        checks++;
        if (sloe !== 1'b0 || slrd !== 1'b1) begin
            errors++;
            $display("FAIL single_oe: got sloe=%b slrd=%b expected 0 1", sloe, slrd);
        end
        tick();  // E1: RD
        checks++;
        if (slrd !== 1'b0) begin
            errors++;
            $display("FAIL single_rd: got slrd=%b expected 0", slrd);
        end
        tick();  // E2: byte captured, GAP
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || slrd !== 1'b1) begin
            errors++;
            $display("FAIL single_data: got valid=%b data=%02h slrd=%b expected 1 a5 1",
                     m_valid, m_data, slrd);
        end
        tick();  // E3: flag low -> IDLE
        checks++;
        if (sloe !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got sloe=%b valid=%b expected 1 0", sloe, m_valid);
        end
        tick();
        checks++;
        if (strobes - s0 != 1 || popped - p0 != 1) begin
            errors++;
            $display("FAIL single_count: got strobes=%0d pops=%0d expected 1 1",
                     strobes - s0, popped - p0);
        end
    endtask

    task automatic test_stream();
        int s0 = strobes;
        int p0 = popped;
        m_ready = 1'b1;
        first_strobe_cyc = -1;
        for (int i = 0; i < 64; i++) fx2_q.push_back(8'(i));
        for (int t = 0; t < 400; t++) begin
            if (popped - p0 >= 64) break;
            tick();
        end
        tick();
        checks++;
        if (popped - p0 != 64 || strobes - s0 != 64) begin
            errors++;
            $display("FAIL stream_count: got pops=%0d strobes=%0d expected 64 64",
                     popped - p0, strobes - s0);
        end
        checks++;
        if (last_strobe_cyc - first_strobe_cyc != 126) begin
            errors++;
            $display("FAIL stream_rate: got span %0d cycles expected 126",
                     last_strobe_cyc - first_strobe_cyc);
        end
    endtask

    task automatic test_back_pressure();
        int s0 = strobes;
        int p0 = popped;
        logic [7:0] held;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) fx2_q.push_back(8'hC0 + 8'(i));
        repeat (60) tick();
        checks++;
        if (level !== 4'd8 || strobes - s0 != 8) begin
            errors++;
            $display("FAIL bp_full: got level=%0d strobes=%0d expected 8 8", level, strobes - s0);
        end
        checks++;
        if (slrd !== 1'b1 || sloe !== 1'b1 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: got slrd=%b sloe=%b valid=%b expected 1 1 1", slrd, sloe, m_valid);
        end
        held = m_data;
        checks++;
        if (held !== 8'hC0) begin
            errors++;
            $display("FAIL bp_head: got %02h expected c0", held);
        end
        repeat (10) tick();
        checks++;
        if (m_data !== 8'hC0 || strobes - s0 != 8) begin
            errors++;
            $display("FAIL bp_hold: got data=%02h strobes=%0d expected c0 8", m_data, strobes - s0);
        end
        m_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (popped - p0 >= 20 && level === 4'd0) break;
            tick();
        end
        tick();
        checks++;
        if (popped - p0 != 20 || strobes - s0 != 20 || level !== 4'd0) begin
            errors++;
            $display("FAIL bp_drain: got pops=%0d strobes=%0d level=%0d expected 20 20 0",
                     popped - p0, strobes - s0, level);
        end
    endtask

    task automatic test_flag_drop();
        int  s0 = strobes;
        bit  seen = 1'b0;
        m_ready = 1'b0;
        fx2_q = '{8'h5A, 8'h6B};
        for (int t = 0; t < 20; t++) begin
            tick();
            if (sloe === 1'b0 && slrd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL fd_oe_timeout: got no OE expected OE within 20 cycles");
        end else begin
            fx2_en = 1'b0;
            tick();
            checks++;
            if (slrd !== 1'b0) begin
                errors++;
                $display("FAIL fd_rd: got slrd=%b expected 0", slrd);
            end
            tick();
            tick();
            checks++;
            if (sloe !== 1'b1 || strobes - s0 != 1 || level !== 4'd1 || m_data !== 8'h5A) begin
                errors++;
                $display("FAIL fd_capture: got sloe=%b strobes=%0d level=%0d data=%02h expected 1 1 1 5a",
                         sloe, strobes - s0, level, m_data);
            end
        end
        m_ready = 1'b1;
        tick();
        tick();
        fx2_q.delete();
        fx2_en = 1'b1;
        tick();
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL fd_drain: got level=%0d expected 0", level);
        end
    endtask

    task automatic test_mid_reset();
        int  p0;
        bit  hit = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) fx2_q.push_back(8'h80 + 8'(i));
        for (int t = 0; t < 100; t++) begin
            tick();
            if (level === 4'd5 && slrd === 1'b0) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mr_timeout: got no RD at level 5 expected one within 100 cycles");
        end else begin
            rst_n = 1'b0;
            #1;
            model_level = 0;
            exp_q.delete();
            checks++;
            if (slrd !== 1'b1 || sloe !== 1'b1 || level !== 4'd0 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL mr_async: got slrd=%b sloe=%b level=%0d valid=%b expected 1 1 0 0",
                         slrd, sloe, level, m_valid);
            end
            tick();
            tick();
            rst_n = 1'b1;
            tick();
            checks++;
            if (sloe !== 1'b0 || slrd !== 1'b1) begin
                errors++;
                $display("FAIL mr_restart: got sloe=%b slrd=%b expected 0 1", sloe, slrd);
            end
        end
        p0 = popped;
        m_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (fx2_q.size() == 0 && level === 4'd0) break;
            tick();
        end
        tick();
        checks++;
        if (popped - p0 != 5) begin
            errors++;
            $display("FAIL mr_remaining: got %0d bytes expected 5", popped - p0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flag    = 1'b0;
        fd      = 8'h00;
        m_ready = 1'b0;
        test_reset();
        test_single_byte();
        test_stream();
        test_back_pressure();
        test_flag_drop();
        test_mid_reset();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d undelivered expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
